// File: rtl/lab2_mem_test_master.sv
// Memory test master: writes an incrementing seeded pattern over a word
// range through Avalon-MM, reads it back and reports mismatches.
module lab2_mem_test_master #(
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      LAT     = 3'(RD_LATENCY);

  logic [2:0]        state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       seed_q;
  logic [2:0]        lat;
  logic              gap;

  logic [ADDR_W:0]   len_c;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       pattern;
  logic              last;
  logic              mismatch;
  logic              wr_cmd;
  logic              rd_cmd;

  assign len_c    = (length > MAX_LEN) ? MAX_LEN : length;
  assign cur_addr = base_q + idx[ADDR_W-1:0];
  assign pattern  = seed_q + 32'(idx);
  assign last     = (idx == len_q - 1'b1);
  assign mismatch = (avm_readdata != pattern);

  // gap keeps the read command off for one cycle after the write phase
  assign wr_cmd = (state == S_WRITE);
  assign rd_cmd = (state == S_READ) && !gap;

  assign avm_write      = wr_cmd;
  assign avm_read       = rd_cmd;
  assign avm_address    = (wr_cmd || rd_cmd) ? cur_addr : '0;
  assign avm_writedata  = wr_cmd ? pattern : 32'h0;
  assign avm_byteenable = (wr_cmd || rd_cmd) ? 4'hF : 4'h0;
  assign busy = (state == S_WRITE) || (state == S_READ)
             || (state == S_RWAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      len_q          <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      lat            <= '0;
      gap            <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= len_c;
            seed_q         <= seed;
            idx            <= '0;
            gap            <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= (len_c == '0);
            pass           <= (len_c == '0);
            state <= (len_c == '0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            if (last) begin
              idx   <= '0;
              gap   <= 1'b1;
              state <= S_READ;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_READ: begin
          gap <= 1'b0;
          if (!gap && !avm_waitrequest) begin
            lat   <= 3'd1;
            state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (lat == LAT) begin
            if (mismatch) begin
              if (err_count != 16'hFFFF)
                err_count <= err_count + 1'b1;
              if (err_count == '0)
                first_err_addr <= cur_addr;
            end
            if (last) begin
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == '0);
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end else begin
            lat <= lat + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_mem_test_master.sv
// Bench for lab2_mem_test_master: Avalon slave model plus a scoreboard
// of expected commands checked by an independent monitor.
module tb_lab2_mem_test_master;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [31:0]   seed;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  lab2_mem_test_master #(.ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .length(length), .seed(seed),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {is_read, address, write data (0 for reads)}
  logic [46:0] exp_q[$];

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          rnd_wait = 1'b0;
  logic          corrupt  = 1'b0;
  logic          acc_wr   = 1'b0;
  logic          acc_rd   = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [31:0]   acc_data = '0;
  logic          prev_stall = 1'b0;
  logic [47:0]   prev_cmd   = '0;

  initial avm_waitrequest = 1'b0;
  initial avm_readdata    = 32'h0;

  // slave: acts on the commands the monitor saw accepted
  always @(posedge clk) begin
    avm_waitrequest <= rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    if (acc_wr) mem[acc_addr] <= acc_data;
    if (acc_rd)
      avm_readdata <= mem[acc_addr]
                    ^ ((corrupt && acc_addr == 14'd5) ? 32'h1 : 32'h0);
  end

  // monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      acc_wr     = 1'b0;
      acc_rd     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (avm_read || avm_write) begin
        check("cmd_exclusive", 64'(avm_read & avm_write), 64'h0);
        check("byteenable", 64'(avm_byteenable), 64'hF);
      end
      if (prev_stall)
        check("stall_hold",
              64'({avm_read, avm_write, avm_address, avm_writedata}),
              64'(prev_cmd));
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      prev_cmd   = {avm_read, avm_write, avm_address, avm_writedata};
      acc_wr   = avm_write && !avm_waitrequest;
      acc_rd   = avm_read && !avm_waitrequest;
      acc_addr = avm_address;
      acc_data = avm_writedata;
      if (acc_wr || acc_rd) begin
        if (exp_q.size() == 0)
          check("unexpected_cmd", 64'(avm_address), 64'hFFFF_FFFF);
        else
          check("cmd", 64'({acc_rd, acc_addr,
                             acc_rd ? 32'h0 : acc_data}),
                64'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] n,
                       input logic [31:0] s);
    int words;
    logic [AW-1:0] a;
    words = (n > 15'(1 << AW)) ? (1 << AW) : int'(n);
    for (int i = 0; i < words; i++) begin
      a = b + AW'(i);
      exp_q.push_back({1'b0, a, s + 32'(i)});
    end
    for (int i = 0; i < words; i++) begin
      a = b + AW'(i);
      exp_q.push_back({1'b1, a, 32'h0});
    end
    @(negedge clk);
    base_addr = b;
    length    = n;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic finish_run(input string name, input logic ep,
                            input logic [15:0] ee,
                            input logic [AW-1:0] ef, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, 64'(done), 64'h1);
    check({name, "_busy"}, 64'(busy), 64'h0);
    check({name, "_pass"}, 64'(pass), 64'(ep));
    check({name, "_errs"}, 64'(err_count), 64'(ee));
    check({name, "_first"}, 64'(first_err_addr), 64'(ef));
    check({name, "_leftover"}, 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    seed      = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({avm_read, avm_write, avm_byteenable,
                           avm_address, busy, done, pass}), 64'h0);
    check("rst_wdata", 64'(avm_writedata), 64'h0);
    check("rst_status", 64'({err_count, first_err_addr}), 64'h0);
    reset_n = 1'b1;

    issue(14'h0, 15'd4, 32'h10);
    finish_run("basic", 1'b1, 16'd0, 14'd0, 100);

    issue(14'h3FFE, 15'd4, 32'hA5A5_0000);
    finish_run("wrap", 1'b1, 16'd0, 14'd0, 100);

    corrupt = 1'b1;
    issue(14'h0, 15'd8, 32'h100);
    finish_run("corrupt", 1'b0, 16'd1, 14'd5, 200);
    corrupt = 1'b0;

    rnd_wait = 1'b1;
    issue(14'h200, 15'd16, 32'hFFFF_FFF8);
    finish_run("stall", 1'b1, 16'd0, 14'd0, 2000);
    rnd_wait = 1'b0;

    issue(14'h123, 15'd0, 32'h0);
    finish_run("len0", 1'b1, 16'd0, 14'd0, 20);

    issue(14'h20, 15'd8, 32'h55);
    @(negedge clk);
    check("busy_mid", 64'(busy), 64'h1);
    base_addr = 14'h1000;
    length    = 15'd3;
    seed      = 32'hDEAD;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    finish_run("ignore_start", 1'b1, 16'd0, 14'd0, 200);

    rnd_wait = 1'b1;
    issue(14'h300, 15'd8, 32'h9000);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'({busy, avm_write}), 64'h3);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_write", 64'({avm_write, avm_read}), 64'h0);
    check("midrst_status", 64'({busy, done, pass, err_count,
                                first_err_addr}), 64'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    issue(14'h40, 15'd4, 32'h7);
    finish_run("after_rst", 1'b1, 16'd0, 14'd0, 1000);
    rnd_wait = 1'b0;

    issue(14'h3FF0, 15'h4005, 32'hDEAD_0000);
    finish_run("clamp", 1'b1, 16'd0, 14'd0, 60000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
